// File: rtl/mac_if.sv
// Streaming handshake bundle for mac_pipe: operand beat in, result out.
// slave = the MAC block, master = the upstream/downstream environment.
interface mac_if #(
  parameter int DW    = 16,
  parameter int LANES = 2,
  parameter int ACCW  = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [LANES*DW-1:0]   a_in;
  logic [LANES*DW-1:0]   b_in;
  logic [ACCW-1:0]       c_in;
  logic                  acc_mode;
  logic                  acc_clr;
  logic                  out_valid;
  logic                  out_ready;
  logic [ACCW-1:0]       sum_out;

  modport master (
    output in_valid, a_in, b_in, c_in, acc_mode, acc_clr, out_ready,
    input  in_ready, out_valid, sum_out
  );
  modport slave (
    input  in_valid, a_in, b_in, c_in, acc_mode, acc_clr, out_ready,
    output in_ready, out_valid, sum_out
  );
endinterface

// File: rtl/mac_pipe.sv
// Two-stage pipelined N-lane signed dot-product MAC with valid/ready flow control.
// Optional MAC_SAT_EN: saturate the final sum (and stored accumulator) instead of wrapping.
module mac_lane #(
  parameter int DW = 16
) (
  input  logic signed [DW-1:0]   a,
  input  logic signed [DW-1:0]   b,
  output logic signed [2*DW-1:0] p
);
  assign p = a * b;
endmodule

module mac_pipe #(
  parameter int DW    = 16,
  parameter int LANES = 2,
  parameter int ACCW  = 32
) (
  input logic clk,
  input logic rst_n,
  mac_if.slave bus
);
  localparam int STAGES = 2;
  localparam int PW     = 2 * DW;

  if (LANES < 1) begin : g_bad_lanes
    $error("mac_pipe: LANES must be >= 1");
  end
  if (ACCW < PW + $clog2(LANES)) begin : g_bad_accw
    $error("mac_pipe: ACCW too narrow for full-precision lane sum");
  end

  typedef struct packed {
    logic [LANES-1:0][PW-1:0] prod;
    logic [ACCW-1:0]          c;
    logic                     mode;
    logic                     clr;
  } s1_t;

  logic [LANES-1:0][DW-1:0] a_v, b_v;
  logic [LANES-1:0][PW-1:0] prod;

  assign a_v = bus.a_in;
  assign b_v = bus.b_in;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    mac_lane #(.DW(DW)) u_lane (
      .a (a_v[g]),
      .b (b_v[g]),
      .p (prod[g])
    );
  end

  s1_t               s1_q, s1_d;
  logic [STAGES:1]   vld_pipe_q, vld_pipe_d;
  logic [ACCW-1:0]   sum_q, sum_d;
  logic [ACCW-1:0]   acc_q, acc_d;
  logic              stall, s1_en;
  logic [ACCW-1:0]   addend;
  logic [ACCW:0]     tot;
  logic [ACCW-1:0]   res;

  always_comb begin
    stall  = vld_pipe_q[2] & ~bus.out_ready;
    // S1 may refill a bubble even while S2 is stalled.
    s1_en  = ~stall | ~vld_pipe_q[1];

    if (!s1_q.mode)     addend = s1_q.c;
    else if (s1_q.clr)  addend = '0;
    else                addend = acc_q;

    tot = {addend[ACCW-1], addend};
    for (int i = 0; i < LANES; i++)
      tot = tot + {{(ACCW+1-PW){s1_q.prod[i][PW-1]}}, s1_q.prod[i]};

`ifdef MAC_SAT_EN
    if (tot[ACCW] != tot[ACCW-1])
      res = tot[ACCW] ? {1'b1, {(ACCW-1){1'b0}}} : {1'b0, {(ACCW-1){1'b1}}};
    else
      res = tot[ACCW-1:0];
`else
    res = tot[ACCW-1:0];
`endif

    s1_d       = s1_q;
    vld_pipe_d = vld_pipe_q;
    sum_d      = sum_q;
    acc_d      = acc_q;

    if (s1_en) begin
      vld_pipe_d[1] = bus.in_valid;
      if (bus.in_valid) begin
        s1_d.prod = prod;
        s1_d.c    = bus.c_in;
        s1_d.mode = bus.acc_mode;
        s1_d.clr  = bus.acc_clr;
      end
    end

    // Accumulator and result register load on the same edge, so chained
    // acc_mode beats see the previous result without a forwarding path.
    if (!stall) begin
      vld_pipe_d[2] = vld_pipe_q[1];
      if (vld_pipe_q[1]) begin
        sum_d = res;
        if (s1_q.mode) acc_d = res;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q       <= '0;
      vld_pipe_q <= '0;
      sum_q      <= '0;
      acc_q      <= '0;
    end else begin
      s1_q       <= s1_d;
      vld_pipe_q <= vld_pipe_d;
      sum_q      <= sum_d;
      acc_q      <= acc_d;
    end
  end

  assign bus.in_ready  = s1_en;
  assign bus.out_valid = vld_pipe_q[2];
  assign bus.sum_out   = sum_q;
endmodule
